// File: rtl/im_fetch_ctrl.sv
// Instruction-memory sequencer: the host loader owns the byte-write port in BOOT,
// and the CPU fetch path owns the read address in RUN. Bad fetches latch FAULT.
module im_fetch_ctrl #(
    parameter int MEM_SIZE = 128,
    parameter int AW       = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_wr_en,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_data,
    input  logic          host_load_done,
    input  logic          host_reload,
    output logic          host_wr_err,
    output logic [AW:0]   loaded_cnt,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_ready,
    output logic          fetch_valid,
    output logic [31:0]   fetch_instr,
    output logic          fault,
    output logic [31:0]   im_addr,
    input  logic [31:0]   im_instr,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [7:0]    im_wdata
);

    localparam logic [AW:0] SIZE_W    = MEM_SIZE[AW:0];
    localparam logic [31:0] FETCH_MAX = 32'(MEM_SIZE - 4);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_busy;
    logic   w_wr_ok;
    logic   w_good;
    logic   w_accept;

    assign w_wr_ok  = host_wr_en && (r_state == S_BOOT) && ({1'b0, host_addr} < SIZE_W);
    assign w_good   = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= FETCH_MAX);
    assign w_accept = fetch_req && fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_BOOT;
        else        r_state <= w_next;
    end

    // Reload has priority everywhere; it also blocks fetch acceptance.
    always_comb begin
        w_next      = r_state;
        fetch_ready = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (!host_reload && host_load_done) w_next = S_RUN;
            end
            S_RUN: begin
                fetch_ready = !r_busy && !host_reload;
                if (host_reload)            w_next = S_BOOT;
                else if (w_accept && !w_good) w_next = S_FAULT;
            end
            S_FAULT: begin
                if (host_reload) w_next = S_BOOT;
            end
            default: w_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we       <= 1'b0;
            im_waddr    <= '0;
            im_wdata    <= '0;
            host_wr_err <= 1'b0;
            loaded_cnt  <= '0;
        end else begin
            im_we       <= w_wr_ok;
            host_wr_err <= host_wr_en && !w_wr_ok;
            if (w_wr_ok) begin
                im_waddr <= host_addr;
                im_wdata <= host_data;
            end
            if (host_reload)
                loaded_cnt <= '0;
            else if (w_wr_ok && (loaded_cnt != SIZE_W))
                loaded_cnt <= loaded_cnt + 1'b1;
        end
    end

    // Fetch pipe: accept registers the address, the next cycle reads memory,
    // and the word is returned the cycle after unless a reload drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            im_addr     <= '0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fault       <= 1'b0;
        end else begin
            r_busy      <= w_accept && w_good;
            fetch_valid <= r_busy && !host_reload;
            if (w_accept && w_good)     im_addr     <= fetch_addr;
            if (r_busy && !host_reload) fetch_instr <= im_instr;
            if (host_reload)              fault <= 1'b0;
            else if (w_accept && !w_good) fault <= 1'b1;
        end
    end

endmodule
